clause_fetch: RTL

Sequential reader for the BCP clause memory. On a `start` pulse it walks clause addresses 0 to DEPTH-1 through the memory's single-cycle registered read port, absorbing the one-cycle read latency. It forwards each clause word with its index to the BCP evaluator over a valid/ready stream, and pulses `done` once every clause has been delivered. It is the initiator on the `data_mem_*` port and never writes.

---
 rtl/clause_fetch_if.sv | 26 ++
 rtl/clause_fetch.sv | 110 +++++++++++
 2 files changed

// File: rtl/clause_fetch_if.sv
// clause_fetch_if: clause-memory read port plus the clause valid/ready stream.
interface clause_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] data_mem_address;
  logic              data_mem_en;
  logic              data_mem_write;
  logic [DATA_W-1:0] data_mem_in;
  logic [DATA_W-1:0] data_mem_out;
  logic [DATA_W-1:0] clause_data;
  logic [ADDR_W-1:0] clause_idx;
  logic              clause_last;
  logic              clause_valid;
  logic              clause_ready;
  modport master (
    output data_mem_address, data_mem_en, data_mem_write, data_mem_in,
    output clause_data, clause_idx, clause_last, clause_valid,
    input  data_mem_out, clause_ready
  );
  modport slave (
    input  data_mem_address, data_mem_en, data_mem_write, data_mem_in,
    input  clause_data, clause_idx, clause_last, clause_valid,
    output data_mem_out, clause_ready
  );
endinterface

// File: rtl/clause_fetch.sv
// clause_fetch: scans clause memory 0..DEPTH-1 and streams words out; CLAUSE_FETCH_SKIP_EMPTY_EN drops all-zero slots.
`ifndef INITIAL_DATA_SIZE
`define INITIAL_DATA_SIZE 32
`endif
`ifndef CLAUSE_NUM
`define CLAUSE_NUM 16
`endif
`ifndef CLAUSE_NUM_LOG
`define CLAUSE_NUM_LOG 4
`endif
module clause_fetch #(
  parameter int DATA_W = `INITIAL_DATA_SIZE,
  parameter int DEPTH  = `CLAUSE_NUM,
  parameter int ADDR_W = `CLAUSE_NUM_LOG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  clause_fetch_if.master bus,
  output logic           busy,
  output logic           done
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [ADDR_W-1:0] last_idx = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, addr_q, addr_d, i0_q, i0_d, i1_q, i1_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0] cnt_q, cnt_d, fill;
  logic all_issued_q, all_issued_d, inflight_q, done_q, done_d;
  logic scan, valid, issue, pop, push, keep, start_scan;

  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

  always_comb state_d = state_q == IDLE ? (start && !abort ? SCAN : IDLE)
                                        : (abort || done_q ? IDLE : SCAN);

  always_comb begin
    scan = state_q == SCAN;
    valid = cnt_q != 2'd0;
    pop = valid && bus.clause_ready;
    // a new read may only go out if its word is guaranteed a FIFO slot on capture
    issue = scan && !abort && !all_issued_q &&
            ({1'b0, cnt_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    bus.data_mem_en = issue;
    bus.data_mem_address = issue ? next_addr_q : addr_q;
    bus.data_mem_write = 1'b0;
    bus.data_mem_in = '0;
    bus.clause_valid = valid;
    bus.clause_data = d0_q;
    bus.clause_idx = i0_q;
    bus.clause_last = valid && i0_q == last_idx;
    busy = scan;
    done = done_q;
  end

  always_comb begin
`ifdef CLAUSE_FETCH_SKIP_EMPTY_EN
    keep = bus.data_mem_out != '0;
`else
    keep = 1'b1;
`endif
    push = scan && !abort && inflight_q && keep;
    fill = cnt_q - {1'b0, pop};
    d0_d = pop ? d1_q : d0_q;
    i0_d = pop ? i1_q : i0_q;
    d1_d = d1_q;
    i1_d = i1_q;
    if (push && fill == 2'd0) begin
      d0_d = bus.data_mem_out;
      i0_d = addr_q;
    end
    if (push && fill != 2'd0) begin
      d1_d = bus.data_mem_out;
      i1_d = addr_q;
    end
    cnt_d = scan && abort ? 2'd0 : fill + {1'b0, push};
    start_scan = state_q == IDLE && start && !abort;
    next_addr_d = start_scan ? '0 : (issue && next_addr_q != last_idx ? next_addr_q + 1'b1 : next_addr_q);
    all_issued_d = start_scan ? 1'b0 : all_issued_q || (issue && next_addr_q == last_idx);
    addr_d = bus.data_mem_address;
    done_d = scan && !abort && !done_q && all_issued_q && !inflight_q && fill == 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr_q  <= '0;
      addr_q       <= '0;
      all_issued_q <= 1'b0;
      inflight_q   <= 1'b0;
      cnt_q        <= 2'd0;
      d0_q         <= '0;
      d1_q         <= '0;
      i0_q         <= '0;
      i1_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      next_addr_q  <= next_addr_d;
      addr_q       <= addr_d;
      all_issued_q <= all_issued_d;
      inflight_q   <= issue;
      cnt_q        <= cnt_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      i0_q         <= i0_d;
      i1_q         <= i1_d;
      done_q       <= done_d;
    end
  end
endmodule
